// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   tx_state_e    - transmitter FSM states
//   clks_per_bit  - sys_clk cycles per serial bit (integer truncation)
//   START_BIT / STOP_BIT / DATA_BITS - 8N1 frame constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sender_if.sv
// uart_sender_if: valid/ready byte handshake from the CPU peripheral bus.
//   tx_data  - byte to send, sampled when tx_valid && tx_ready
//   tx_valid - producer has a byte on tx_data
//   tx_ready - transmitter can accept a byte this cycle
// master = producer (CPU side), slave = uart_sender.
interface uart_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering bytes ahead of the serializer.
//   i_clk, i_reset - clock and synchronous active-high reset
//   i_push, i_data - write request and word; ignored while full
//   i_pop          - read request; ignored while empty
//   o_full, o_empty, o_head - status flags and the word at the head
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == (AW+1)'(0));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage write; data words need no reset since occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop keeps occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - (AW+1)'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

endmodule

// File: rtl/uart_sender.sv
// uart_sender: 8N1 UART transmitter driving the UART_TX pin.
//   i_sys_clk - system clock, all logic on the rising edge
//   i_reset   - synchronous active-high reset; aborts any frame, drops buffered bytes
//   s_tx      - valid/ready byte input (tx_data, tx_valid, tx_ready = FIFO not full)
//   o_uart_tx - serial line, idles high, driven from a register
//   o_tx_busy - high while a frame is on the line or bytes are buffered
// Frame: start bit 0, data LSB first, stop bit 1; each bit CLKS_PER_BIT cycles.
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          i_sys_clk,
  input  logic          i_reset,
  uart_sender_if.slave  s_tx,
  output logic          o_uart_tx,
  output logic          o_tx_busy
);

  localparam int             CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int             BCW          = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BAUD_LAST    = BCW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST     = 3'(DATA_BITS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  logic [1:0]     r_state;
  logic [BCW-1:0] r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;

  logic [1:0]     w_state_nxt;
  logic [BCW-1:0] w_baud_nxt;
  logic [2:0]     w_bit_idx_nxt;
  logic [7:0]     w_shift_nxt;
  logic           w_tx_nxt;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_head;
  logic           w_baud_done;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_sys_clk),
    .i_reset (i_reset),
    .i_push  (s_tx.tx_valid),
    .i_data  (s_tx.tx_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign s_tx.tx_ready = !w_full;
  assign o_uart_tx     = r_tx;
  assign o_tx_busy     = (r_state != ST_IDLE) || !w_empty;
  assign w_baud_done   = (r_baud == BAUD_LAST);

  // Next-state logic for the FSM, baud counter, bit index and shift register
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + BCW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = BCW'(0);
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_START;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = BCW'(0);
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = BCW'(0);
          if (r_bit_idx == BIT_LAST) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = BCW'(0);
          // A queued byte starts immediately so back-to-back frames have no gap
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = ST_START;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = BCW'(0);
      end
    endcase
  end

  // Line level for the upcoming cycle, so UART_TX comes straight from a flop
  always_comb begin
    w_tx_nxt = STOP_BIT;
    case (w_state_nxt)
      ST_IDLE:  w_tx_nxt = STOP_BIT;
      ST_START: w_tx_nxt = START_BIT;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      ST_STOP:  w_tx_nxt = STOP_BIT;
      default:  w_tx_nxt = STOP_BIT;
    endcase
  end

  // Transmitter state registers
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= BCW'(0);
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= STOP_BIT;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: self-checking bench for uart_sender at 10 clocks per bit.
// A cycle-offset frame model predicts UART_TX/tx_busy/tx_ready every cycle,
// a mid-bit serial decoder checks bytes against push order, and directed
// tests pin the model with hand-computed values.
module tb_uart_sender;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic busy;

  uart_sender_if u_if ();

  uart_sender #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .s_tx      (u_if),
    .o_uart_tx (tx),
    .o_tx_busy (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // model state
  logic [7:0] m_q[$];
  logic [7:0] sb[$];
  bit         m_act = 1'b0;
  int         m_off = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_acc = 1'b0;

  // decoder state
  bit         d_act = 1'b0;
  int         d_start = 0;
  int         d_off = 0;
  logic [7:0] d_byte = 8'h00;
  int         d_count = 0;
  logic [7:0] dec_bytes[$];
  int         dec_starts[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    if (m_off < CPB) return 1'b0;
    if (m_off >= 9 * CPB) return 1'b1;
    return m_cur[m_off / CPB - 1];
  endfunction

  task automatic model_step();
    bit rdy;
    m_acc = 1'b0;
    if (rst) begin
      m_q.delete();
      sb.delete();
      m_act = 1'b0;
      m_off = 0;
    end else begin
      rdy = (m_q.size() < DEPTH);
      if (m_act) begin
        m_off++;
        if (m_off == FRAME) m_act = 1'b0;
      end
      if (!m_act && m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_act = 1'b1;
        m_off = 0;
      end
      if (u_if.tx_valid && rdy) begin
        m_q.push_back(u_if.tx_data);
        sb.push_back(u_if.tx_data);
        m_acc = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("line", tx, exp_tx());
      chk("busy", busy, (m_act || m_q.size() != 0));
      chk("ready", u_if.tx_ready, (m_q.size() < DEPTH));
    end
  end

  // serial decoder sampling mid-bit
  initial forever begin
    @(negedge clk);
    if (rst) begin
      d_act = 1'b0;
    end else if (!d_act) begin
      if (chk_en && tx === 1'b0) begin
        d_act = 1'b1;
        d_start = cyc;
      end
    end else begin
      d_off = cyc - d_start;
      if (d_off >= 15 && d_off <= 85 && (d_off % 10) == 5)
        d_byte[(d_off - 15) / 10] = tx;
      if (d_off == 95) begin
        chk("stop_bit", tx, 1);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL dec_unexpected: got byte %0h expected none (cycle %0d)", d_byte, cyc);
        end else begin
          chk("decoded_byte", d_byte, sb.pop_front());
        end
        dec_bytes.push_back(d_byte);
        dec_starts.push_back(d_start);
        d_count++;
        d_act = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push1(input logic [7:0] b);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = b;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((m_act || m_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_total++;
      $display("FAIL %s_timeout: got still busy expected idle within 3000 cycles", name);
    end
    tick(5);
  endtask

  initial begin
    int n0;
    int sent;
    int base;
    int bound;
    rst = 1'b1;
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;

    // reset and idle
    tick(3);
    chk_en = 1'b1;
    chk("reset_tx", tx, 1);
    chk("reset_ready", u_if.tx_ready, 1);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick(200);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);

    // single byte 0x55
    @(negedge clk);
    push1(8'h55);
    n0 = cyc;
    chk("single_busy_N", busy, 1);
    chk("single_tx_N", tx, 1);
    wait_until(n0 + 1);   chk("single_start_first", tx, 0);
    wait_until(n0 + 10);  chk("single_start_last", tx, 0);
    wait_until(n0 + 11);  chk("single_d0", tx, 1);
    wait_until(n0 + 21);  chk("single_d1", tx, 0);
    wait_until(n0 + 81);  chk("single_d7", tx, 0);
    wait_until(n0 + 91);  chk("single_stop", tx, 1);
    wait_until(n0 + 100); chk("single_busy_last", busy, 1);
    wait_until(n0 + 101); chk("single_busy_fall", busy, 0);
    drain("single");
    chk("single_decoded", dec_bytes.size(), 1);
    if (dec_bytes.size() == 1) chk("single_value", dec_bytes[0], 8'h55);

    // back-to-back 0xA3, 0x0F
    dec_bytes.delete();
    dec_starts.delete();
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'hA3;
    @(negedge clk);
    u_if.tx_data  = 8'h0F;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    drain("b2b");
    chk("b2b_count", dec_bytes.size(), 2);
    if (dec_bytes.size() == 2) begin
      chk("b2b_byte0", dec_bytes[0], 8'hA3);
      chk("b2b_byte1", dec_bytes[1], 8'h0F);
      chk("b2b_spacing", dec_starts[1] - dec_starts[0], FRAME);
    end

    // FIFO full: continuous valid with incrementing bytes
    base = d_count;
    sent = 0;
    bound = 0;
    n0 = 0;
    u_if.tx_data  = 8'h00;
    u_if.tx_valid = 1'b1;
    while (sent < 12 && bound < 3000) begin
      @(negedge clk);
      bound++;
      if (m_acc) begin
        sent++;
        if (sent == 1) n0 = cyc;
        u_if.tx_data = u_if.tx_data + 8'd1;
      end
      if (sent >= 1 && cyc == n0 + 3) chk("full_ready_3", u_if.tx_ready, 1);
      if (sent >= 1 && cyc == n0 + 4) chk("full_ready_4", u_if.tx_ready, 0);
    end
    u_if.tx_valid = 1'b0;
    if (bound >= 3000) begin
      n_total++;
      $display("FAIL full_timeout: got %0d bytes accepted expected 12", sent);
    end
    drain("full");
    chk("full_count", d_count - base, 12);

    // reset during data bit 3 of 0xFF with two bytes queued
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'hFF;
    @(negedge clk);
    n0 = cyc;
    u_if.tx_data  = 8'h11;
    @(negedge clk);
    u_if.tx_data  = 8'h22;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    wait_until(n0 + 44);
    chk("rst_midframe_line", tx, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_edge_tx", tx, 1);
    chk("rst_edge_busy", busy, 0);
    chk("rst_edge_ready", u_if.tx_ready, 1);
    tick(2);
    rst = 1'b0;
    base = d_count;
    tick(200);
    chk("rst_no_frames", d_count - base, 0);
    chk("rst_tx_idle", tx, 1);

    // 256 random bytes
    base = d_count;
    for (int i = 0; i < 256; i++) begin
      bound = 0;
      while (m_q.size() >= DEPTH && bound < 500) begin
        @(negedge clk);
        bound++;
      end
      u_if.tx_data  = 8'($urandom_range(255, 0));
      u_if.tx_valid = 1'b1;
      @(negedge clk);
      u_if.tx_valid = 1'b0;
    end
    drain("random");
    chk("random_count", d_count - base, 256);
    chk("random_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_sender.md
# uart_sender

Synthesizable 8N1 UART transmitter for the CPU's UART_TX pin, the outbound counterpart of the serial receive path. It accepts bytes from the CPU peripheral bus over a valid/ready handshake. Bytes are buffered in a small FIFO and serialized LSB-first at a fixed baud rate derived from sys_clk. Default timing gives 100 MHz / 9600 baud, 10416 clocks per bit, matching the board's serial link.

## Interface
- CLK_FREQ, 100_000_000: sys_clk frequency in Hz.
- BAUD, 9600: line rate in bits per second.
- FIFO_DEPTH, 4: byte buffer entries; must be a power of two, ≥2.
- sys_clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  FIFO not full; byte accepted on any edge where tx_valid && tx_ready.
- UART_TX  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- CLKS_PER_BIT = CLK_FREQ / BAUD, integer truncation; must be ≥2.
- Frame layout: start bit 0, then data[0]..data[7], then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: UART_TX=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and go to START.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: UART_TX=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment bit_idx (0..7). After bit 7 completes, go to STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles. If the FIFO is non-empty at the final cycle, pop and go directly to START. Otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1. It resets to 0 on every state or bit change and is held at 0 in IDLE.
- UART_TX is driven from a register, so the output is glitch-free.
- FIFO:
  - tx_ready = !full.
  - A push while full is ignored. This cannot occur legally, because ready is low.
  - Push and pop in the same cycle are allowed whenever not full; occupancy is unchanged.
  - A push into an empty FIFO is visible to the FSM on the next cycle.
- Reset values: state=IDLE, UART_TX=1, FIFO empty, tx_ready=1, tx_busy=0, counters 0.
- Reset mid-frame aborts the frame. UART_TX returns to 1 on the reset edge and buffered bytes are discarded.

## Timing
- Byte accepted at edge N with the FIFO empty and the FSM in IDLE: the start bit begins at edge N+1, with UART_TX low from N+1.
- One frame = 10·CLKS_PER_BIT cycles.
- Back-to-back bytes produce no idle gap. The next start bit begins on the edge ending the previous stop bit.
- Full-FIFO throughput is one byte per 10·CLKS_PER_BIT cycles. tx_ready rises the cycle after each pop that leaves space.
- tx_busy falls on the edge where STOP exits to IDLE.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the clks_per_bit(CLK_FREQ, BAUD) constant function;
  - the frame constants START_BIT=0, STOP_BIT=1, DATA_BITS=8. The receive side reuses these.
- One sub-module, uart_tx_fifo:
  - synchronous FIFO, parameterized on width and depth;
  - outputs full, empty and head data, with a pop port.
- Top-level uart_sender holds the FSM, baud counter, bit index and shift register.

## Test plan
Bench uses CLK_FREQ=1_000_000 and BAUD=100_000, so CLKS_PER_BIT=10.
- Post-reset idle: hold reset for 3 cycles, then release → UART_TX=1, tx_ready=1, tx_busy=0 for 200 cycles with no traffic.
- Single byte: push 0x55 at edge N.
  - UART_TX=0 on cycles N+1..N+10.
  - Data bits 1,0,1,0,1,0,1,0 follow, 10 cycles each.
  - Stop bit high on N+91..N+100.
  - tx_busy low after N+100.
- Back-to-back: push 0xA3 then 0x0F on consecutive cycles → two frames totaling 200 cycles. The second start bit begins exactly 100 cycles after the first, and the decoded bytes are 0xA3, 0x0F.
- FIFO full: hold tx_valid high with incrementing bytes 0x00.. → tx_ready drops once 4 bytes are buffered behind the frame in flight. Each pop re-raises ready for one accept. All bytes appear on the line in order with no loss or duplication.
- Reset mid-frame: assert reset during data bit 3 of 0xFF with 2 bytes queued → UART_TX=1 on the reset edge. The FIFO is empty, and no further frames are sent after release.
- Self-check: a bench-side serial decoder sampling mid-bit compares 256 random bytes against a push-order scoreboard → zero mismatches and no framing errors (stop bit = 1).
